// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
    localparam logic [1:0]  WORD_ALIGN_MASK  = 2'b11;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] & WORD_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: runs a req/ack handshake with data memory for one
// load/store at a time and stalls the pipeline until the access completes.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] WriteData_i,
    output logic [31:0] ReadData_o,
    output logic        pcEnable_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_err_o,
    output logic [31:0] stall_cnt_o
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             access;
    logic             aligned;
    logic             conflict;

    assign access   = MemRead_i | MemWrite_i;
    assign aligned  = is_word_aligned(addr_i);
    assign conflict = MemRead_i & MemWrite_i;

    // A misaligned access never stalls: it is rejected in the same IDLE cycle.
    always_comb begin
        pcEnable_o = 1'b1;
        unique case (state)
            IDLE:    pcEnable_o = !(access && aligned);
            BUSY:    pcEnable_o = 1'b0;
            DONE:    pcEnable_o = 1'b1;
            default: pcEnable_o = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            ReadData_o  <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_err_o   <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            if (!pcEnable_o) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end

            unique case (state)
                IDLE: begin
                    if (access && aligned) begin
                        mem_addr_o  <= {addr_i[31:2], 2'b00};
                        mem_wdata_o <= WriteData_i;
                        mem_we_o    <= MemWrite_i;
                        mem_req_o   <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= BUSY;
                        if (conflict) begin
                            mem_err_o <= 1'b1;
                        end
                    end else if (access) begin
                        mem_err_o <= 1'b1;
                    end
                end

                // Ack wins over timeout when both land on the last allowed cycle.
                BUSY: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        if (!mem_we_o) begin
                            ReadData_o <= mem_rdata_i;
                        end
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                        if (wait_cnt == CNT_LAST) begin
                            mem_req_o <= 1'b0;
                            mem_err_o <= 1'b1;
                            if (!mem_we_o) begin
                                ReadData_o <= ERR_DATA;
                            end
                            state <= DONE;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl with a short TIMEOUT so the
// timeout path and the ack-on-last-cycle boundary are both reachable.
module tb_mem_access_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] addr_i;
    logic [31:0] WriteData_i;
    logic [31:0] ReadData_o;
    logic        pcEnable_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_o;
    logic [31:0] stall_cnt_o;

    int checkCount = 0;
    int passCount  = 0;
    int cycleCount = 0;

    int   lastStalls;
    int   lastReqCycles;
    int   lastReqRise;
    logic lastStable;
    logic lastDone;
    logic [31:0] lastData;
    int   firstRise;

    mem_access_ctrl #(
        .TIMEOUT (4),
        .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .MemRead_i  (MemRead_i),
        .MemWrite_i (MemWrite_i),
        .addr_i     (addr_i),
        .WriteData_i(WriteData_i),
        .ReadData_o (ReadData_o),
        .pcEnable_o (pcEnable_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_ack_i  (mem_ack_i),
        .mem_rdata_i(mem_rdata_i),
        .mem_err_o  (mem_err_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic clearInputs();
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        addr_i      = '0;
        WriteData_i = '0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
    endtask

    task automatic applyReset();
        @(negedge clk_i);
        rst_i = 1'b0;
        clearInputs();
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    // Present one access, ack it ackAfter cycles after req rises (-1 = never),
    // and record what the pipeline would see until the first pcEnable=1 cycle.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int ackAfter,
                                 input logic [31:0] rdata);
        logic [31:0] expAddr;
        expAddr       = {addr[31:2], 2'b00};
        lastStalls    = 0;
        lastReqCycles = 0;
        lastReqRise   = -1;
        lastStable    = 1'b1;
        lastDone      = 1'b0;
        lastData      = '0;
        @(negedge clk_i);
        MemRead_i   = rd;
        MemWrite_i  = wr;
        addr_i      = addr;
        WriteData_i = wdata;
        mem_ack_i   = 1'b0;
        for (int c = 0; c < 64 && !lastDone; c++) begin
            #1;
            if (pcEnable_o) begin
                lastDone = 1'b1;
                lastData = ReadData_o;
            end else begin
                lastStalls++;
            end
            if (mem_req_o) begin
                if (lastReqRise < 0) lastReqRise = cycleCount;
                if (mem_addr_o !== expAddr || mem_we_o !== wr || mem_wdata_o !== wdata)
                    lastStable = 1'b0;
            end
            if (mem_req_o && ackAfter >= 0 && lastReqCycles == ackAfter) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rdata;
            end else begin
                mem_ack_i   = 1'b0;
                mem_rdata_i = 32'hFFFF_FFFF;
            end
            if (mem_req_o) lastReqCycles++;
            if (!lastDone) @(negedge clk_i);
        end
        @(posedge clk_i);
        #1;
        clearInputs();
        checkOutput("accessDone", {31'd0, lastDone}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i = 1'b0;
        clearInputs();
        repeat (2) @(negedge clk_i);
        checkOutput("rstReadData", ReadData_o, 32'h0);
        checkOutput("rstReq", {31'd0, mem_req_o}, 32'd0);
        checkOutput("rstErr", {31'd0, mem_err_o}, 32'd0);
        checkOutput("rstStall", stall_cnt_o, 32'd0);
        checkOutput("rstPcEn", {31'd0, pcEnable_o}, 32'd1);
        checkOutput("rstAddr", mem_addr_o, 32'h0);
        rst_i = 1'b1;

        // Load, ack on the 4th BUSY cycle (also the last before timeout).
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 3, 32'h1234_5678);
        checkOutput("loadData", lastData, 32'h1234_5678);
        checkOutput("loadStalls", 32'(lastStalls), 32'd5);
        checkOutput("loadStallCnt", stall_cnt_o, 32'd5);
        checkOutput("loadStable", {31'd0, lastStable}, 32'd1);
        checkOutput("loadErr", {31'd0, mem_err_o}, 32'd0);
        checkOutput("loadReqDrop", {31'd0, mem_req_o}, 32'd0);

        // Store with immediate ack.
        applyStimulus(1'b0, 1'b1, 32'h204, 32'hCAFE_F00D, 0, 32'h5555_5555);
        checkOutput("storeStalls", 32'(lastStalls), 32'd2);
        checkOutput("storeStable", {31'd0, lastStable}, 32'd1);
        checkOutput("storeReqSeen", {31'd0, lastReqCycles > 0}, 32'd1);
        checkOutput("storeReadData", ReadData_o, 32'h1234_5678);
        checkOutput("storeStallCnt", stall_cnt_o, 32'd7);

        // Misaligned load is rejected without a memory request.
        applyStimulus(1'b1, 1'b0, 32'h103, 32'h0, 0, 32'h9999_9999);
        checkOutput("misStalls", 32'(lastStalls), 32'd0);
        checkOutput("misReqCycles", 32'(lastReqCycles), 32'd0);
        checkOutput("misErr", {31'd0, mem_err_o}, 32'd1);
        checkOutput("misReadData", ReadData_o, 32'h1234_5678);
        checkOutput("misStallCnt", stall_cnt_o, 32'd7);

        // Reset pulsed while BUSY.
        @(negedge clk_i);
        MemRead_i = 1'b1;
        addr_i    = 32'h300;
        repeat (2) @(negedge clk_i);
        checkOutput("busyReq", {31'd0, mem_req_o}, 32'd1);
        rst_i = 1'b0;
        clearInputs();
        #1;
        checkOutput("midRstReq", {31'd0, mem_req_o}, 32'd0);
        checkOutput("midRstReadData", ReadData_o, 32'h0);
        checkOutput("midRstErr", {31'd0, mem_err_o}, 32'd0);
        checkOutput("midRstStall", stall_cnt_o, 32'd0);
        checkOutput("midRstAddr", mem_addr_o, 32'h0);
        checkOutput("midRstPcEn", {31'd0, pcEnable_o}, 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Back-to-back loads, each acked immediately.
        applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 0, 32'h1111_1111);
        firstRise = lastReqRise;
        checkOutput("b2bData1", lastData, 32'h1111_1111);
        checkOutput("b2bStalls1", 32'(lastStalls), 32'd2);
        applyStimulus(1'b1, 1'b0, 32'h404, 32'h0, 0, 32'h2222_2222);
        checkOutput("b2bData2", lastData, 32'h2222_2222);
        checkOutput("b2bSpacing", 32'(lastReqRise - firstRise), 32'd3);
        checkOutput("b2bStallCnt", stall_cnt_o, 32'd4);
        checkOutput("b2bErr", {31'd0, mem_err_o}, 32'd0);

        // Stray ack while IDLE must not touch ReadData.
        @(negedge clk_i);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h7777_7777;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        checkOutput("idleAckData", ReadData_o, 32'h2222_2222);
        checkOutput("idleAckPcEn", {31'd0, pcEnable_o}, 32'd1);

        // Conflicting read+write is performed as a write and flagged.
        applyStimulus(1'b1, 1'b1, 32'h600, 32'h0BAD_F00D, 1, 32'h3333_3333);
        checkOutput("conflictStalls", 32'(lastStalls), 32'd3);
        checkOutput("conflictAsWrite", {31'd0, lastStable}, 32'd1);
        checkOutput("conflictErr", {31'd0, mem_err_o}, 32'd1);
        checkOutput("conflictReadData", ReadData_o, 32'h2222_2222);
        checkOutput("conflictStallCnt", stall_cnt_o, 32'd7);

        // Timeout: no ack ever arrives.
        applyReset();
        applyStimulus(1'b1, 1'b0, 32'h500, 32'h0, -1, 32'h0);
        checkOutput("toReqCycles", 32'(lastReqCycles), 32'd4);
        checkOutput("toStalls", 32'(lastStalls), 32'd5);
        checkOutput("toData", lastData, 32'hDEAD_BEEF);
        checkOutput("toErr", {31'd0, mem_err_o}, 32'd1);
        checkOutput("toStallCnt", stall_cnt_o, 32'd5);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
